// File: rtl/reg_dump_sequencer.sv
// -----------------------------------------------------------------------------
// reg_dump_sequencer
//
// Purpose:
//   Debug-side initiator for the register file's debug read port. When a dump
//   is requested it walks register addresses 0..TAM-1 in order. For each
//   address it captures the returned word and serialises it MSB byte first
//   over a valid/ready byte stream toward the debug UART transmitter.
//
// Ports:
//   i_clk              clock, all state updates on the rising edge
//   i_reset            synchronous, active-high reset (aborts any dump)
//   i_start            dump request, only looked at while idle
//   o_reg_debug_addr   address driven to the register file debug port
//   i_reg_debug_data   word returned combinationally for o_reg_debug_addr
//   o_tx_data          byte offered to the transmitter
//   o_tx_valid         o_tx_data is valid
//   i_tx_ready         transmitter takes the byte when o_tx_valid is high
//   o_busy             high while loading or sending
//   o_done             one-cycle pulse after the last byte is accepted
// -----------------------------------------------------------------------------
module reg_dump_sequencer #(
  parameter int REGS = 5,
  parameter int NB   = 32,
  parameter int TAM  = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  output logic [REGS-1:0] o_reg_debug_addr,
  input  logic [NB-1:0]   i_reg_debug_data,
  output logic [7:0]      o_tx_data,
  output logic            o_tx_valid,
  input  logic            i_tx_ready,
  output logic            o_busy,
  output logic            o_done
);

  localparam int NBYTES = NB / 8;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [BW-1:0]   LAST_BYTE = BW'(NBYTES - 1);
  localparam logic [BW-1:0]   ONE_BYTE  = BW'(1);
  localparam logic [REGS-1:0] LAST_REG  = REGS'(TAM - 1);
  localparam logic [REGS-1:0] ONE_REG   = REGS'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [REGS-1:0] reg_idx_q, reg_idx_d;
  logic [BW-1:0]   byte_idx_q, byte_idx_d;
  logic [NB-1:0]   shift_q, shift_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      reg_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    reg_idx_d        = reg_idx_q;
    byte_idx_d       = byte_idx_q;
    shift_d          = shift_q;
    o_reg_debug_addr = '0;
    o_tx_data        = 8'h00;
    o_tx_valid       = 1'b0;
    o_busy           = 1'b0;
    o_done           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_LOAD;
          reg_idx_d = '0;
        end
      end

      S_LOAD: begin
        o_busy           = 1'b1;
        o_reg_debug_addr = reg_idx_q;
        shift_d          = i_reg_debug_data;
        byte_idx_d       = '0;
        state_d          = S_SEND;
      end

      S_SEND: begin
        o_busy           = 1'b1;
        o_tx_valid       = 1'b1;
        o_reg_debug_addr = reg_idx_q;
        // The word is shifted left on every accepted byte, so the byte on
        // offer is always the top byte; byte_idx_q only tracks the word end.
        o_tx_data        = shift_q[NB-1 -: 8];
        if (i_tx_ready) begin
          shift_d = shift_q << 8;
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            if (reg_idx_q == LAST_REG) begin
              state_d = S_DONE;
            end else begin
              reg_idx_d = reg_idx_q + ONE_REG;
              state_d   = S_LOAD;
            end
          end else begin
            byte_idx_d = byte_idx_q + ONE_BYTE;
          end
        end
      end

      S_DONE: begin
        o_done    = 1'b1;
        reg_idx_d = '0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reg_dump_sequencer
//
// Self-checking bench for reg_dump_sequencer. Instance A uses the default
// parameters (32 x 32-bit), instance B uses NB=16, TAM=4. Register contents
// live in bench arrays; the expected byte stream is built from those arrays
// and compared against every accepted byte under random backpressure.
// -----------------------------------------------------------------------------
module tb_reg_dump_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic        a_start = 1'b0;
  logic        a_ready = 1'b0;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic [7:0]  a_txd;
  logic        a_txv, a_busy, a_done;
  logic [31:0] mem_a [32];
  assign a_data = mem_a[a_addr];

  reg_dump_sequencer #(.REGS(5), .NB(32), .TAM(32)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_start(a_start),
    .o_reg_debug_addr(a_addr), .i_reg_debug_data(a_data),
    .o_tx_data(a_txd), .o_tx_valid(a_txv), .i_tx_ready(a_ready),
    .o_busy(a_busy), .o_done(a_done)
  );

  // Instance B: 4 x 16-bit
  logic        b_start = 1'b0;
  logic        b_ready = 1'b0;
  logic [1:0]  b_addr;
  logic [15:0] b_data;
  logic [7:0]  b_txd;
  logic        b_txv, b_busy, b_done;
  logic [15:0] mem_b [4];
  assign b_data = mem_b[b_addr];

  reg_dump_sequencer #(.REGS(2), .NB(16), .TAM(4)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_start(b_start),
    .o_reg_debug_addr(b_addr), .i_reg_debug_data(b_data),
    .o_tx_data(b_txd), .o_tx_valid(b_txv), .i_tx_ready(b_ready),
    .o_busy(b_busy), .o_done(b_done)
  );

  int tests = 0;
  int fails = 0;

  // Drives one dump on instance A starting at the next falling edge and
  // follows it to the DONE cycle. Returns at the falling edge of the DONE
  // cycle, or at the chosen abort point with rst raised.
  task automatic run_dump(input int ready_pct, input bit inject, input bit check_len,
                          input int abort_at);
    logic [7:0] q[$];
    logic [7:0] exp_b;
    logic [7:0] stall_d = 8'h00;
    bit was_stall = 0;
    bit expect_done = 0;
    bit fin = 0;
    int xfers = 0;
    int active = 0;
    for (int r = 0; r < 32; r++)
      for (int b = 0; b < 4; b++)
        q.push_back(mem_a[r][31-8*b -: 8]);

    @(negedge clk);
    a_start = 1'b1;
    a_ready = 1'($urandom_range(1));
    @(negedge clk);
    a_start = 1'b0;
    tests++;
    if (a_busy !== 1'b1 || a_txv !== 1'b0 || a_addr !== 5'd0) begin
      fails++;
      $display("FAIL load_latency: busy=%b valid=%b addr=%0d, required busy=1 valid=0 addr=0",
               a_busy, a_txv, a_addr);
    end

    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      if (cyc == 1) begin
        tests++;
        if (a_txv !== 1'b1) begin
          fails++;
          $display("FAIL first_valid: valid=%b two cycles after start, required 1", a_txv);
        end
      end
      if (a_busy === 1'b1) active++;
      tests++;
      if (a_done !== expect_done) begin
        fails++;
        $display("FAIL done_timing: done=%b after %0d bytes, required %b", a_done, xfers, expect_done);
      end
      if (was_stall) begin
        tests++;
        if (a_txv !== 1'b1 || a_txd !== stall_d) begin
          fails++;
          $display("FAIL stall_hold: valid=%b data=%02h, required valid=1 data=%02h",
                   a_txv, a_txd, stall_d);
        end
      end
      if (a_busy === 1'b1 || a_txv === 1'b1) begin
        tests++;
        if (a_busy !== 1'b1 || a_addr !== 5'(xfers / 4)) begin
          fails++;
          $display("FAIL addr_track: busy=%b addr=%0d, required busy=1 addr=%0d",
                   a_busy, a_addr, xfers / 4);
        end
      end
      if (a_done === 1'b1) begin
        fin = 1;
        tests++;
        if (a_busy !== 1'b0 || a_txv !== 1'b0) begin
          fails++;
          $display("FAIL done_outputs: busy=%b valid=%b, required 0 0", a_busy, a_txv);
        end
        if (check_len) begin
          tests++;
          if (active + 1 != 161) begin
            fails++;
            $display("FAIL dump_length: %0d cycles LOAD entry to DONE, required 161", active + 1);
          end
        end
        a_start = inject;
        a_ready = 1'($urandom_range(1));
      end else begin
        if (abort_at >= 0 && a_txv === 1'b1 && xfers == abort_at) begin
          rst = 1'b1;
          a_ready = 1'b0;
          return;
        end
        a_ready = ($urandom_range(99) < ready_pct);
        a_start = inject ? 1'($urandom_range(1)) : 1'b0;
        was_stall = (a_txv === 1'b1) && !a_ready;
        stall_d = a_txd;
        expect_done = 0;
        if (a_txv === 1'b1 && a_ready) begin
          tests++;
          exp_b = (q.size() > 0) ? q.pop_front() : 8'hxx;
          if (a_txd !== exp_b) begin
            fails++;
            $display("FAIL byte_%0d: got %02h, required %02h", xfers, a_txd, exp_b);
          end
          xfers++;
          if (xfers == 128) expect_done = 1;
        end
        @(negedge clk);
      end
    end
    tests++;
    if (!fin || xfers != 128 || abort_at >= 0) begin
      fails++;
      $display("FAIL dump_end: finished=%0d bytes=%0d abort_at=%0d, required finished=1 bytes=128 no abort",
               fin, xfers, abort_at);
    end
    $display("[TB] dump: %0d bytes, %0d busy cycles, ready %0d%%", xfers, active, ready_pct);
  endtask

  // Checks both instances stay quiet for n cycles with no start.
  task automatic check_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a_start = 1'b0;
      b_start = 1'b0;
      tests++;
      if (a_txv !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_addr !== 5'd0 || a_txd !== 8'h00 ||
          b_txv !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0 || b_addr !== 2'd0 || b_txd !== 8'h00) begin
        fails++;
        $display("FAIL %s: A v=%b b=%b d=%b a=%0d t=%02h B v=%b b=%b d=%b a=%0d t=%02h, required all 0",
                 tag, a_txv, a_busy, a_done, a_addr, a_txd, b_txv, b_busy, b_done, b_addr, b_txd);
      end
      a_ready = 1'($urandom_range(1));
      b_ready = 1'($urandom_range(1));
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle(20, "reset_idle");
    $display("[TB] reset/idle checked");
  endtask

  task automatic test_full_dump;
    for (int i = 0; i < 32; i++) mem_a[i] = 32'(i);
    run_dump(100, 0, 1, -1);
    check_idle(3, "after_full_dump");
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 32; i++) mem_a[i] = $urandom;
    mem_a[3] = 32'hDEADBEEF;
    run_dump(30, 0, 0, -1);
    check_idle(2, "after_backpressure");
  endtask

  task automatic test_start_while_busy;
    for (int i = 0; i < 32; i++) mem_a[i] = $urandom;
    run_dump(60, 1, 0, -1);
    check_idle(4, "start_ignored");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 32; i++) mem_a[i] = $urandom;
    run_dump(100, 0, 1, -1);
    run_dump(100, 0, 1, -1);
    check_idle(2, "after_back_to_back");
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 32; i++) mem_a[i] = $urandom;
    run_dump(100, 0, 0, 42);
    @(negedge clk);
    tests++;
    if (a_txv !== 1'b0 || a_busy !== 1'b0 || a_addr !== 5'd0 || a_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort: valid=%b busy=%b addr=%0d done=%b, required 0 0 0 0",
               a_txv, a_busy, a_addr, a_done);
    end
    rst = 1'b0;
    $display("[TB] reset applied at reg 10 byte 2");
    run_dump(70, 0, 0, -1);
    check_idle(2, "after_reset_mid");
  endtask

  task automatic test_param;
    logic [7:0] q[$];
    logic [7:0] exp_b;
    bit expect_done = 0;
    bit fin = 0;
    int xfers = 0;
    for (int i = 0; i < 4; i++) mem_b[i] = 16'($urandom);
    for (int r = 0; r < 4; r++) begin
      q.push_back(mem_b[r][15:8]);
      q.push_back(mem_b[r][7:0]);
    end
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int cyc = 0; cyc < 500 && !fin; cyc++) begin
      tests++;
      if (b_done !== expect_done) begin
        fails++;
        $display("FAIL p_done_timing: done=%b after %0d bytes, required %b", b_done, xfers, expect_done);
      end
      if (b_done === 1'b1) begin
        fin = 1;
      end else begin
        if (b_busy === 1'b1) begin
          tests++;
          if (b_addr !== 2'(xfers / 2)) begin
            fails++;
            $display("FAIL p_addr: got %0d, required %0d", b_addr, xfers / 2);
          end
        end
        b_ready = ($urandom_range(99) < 50);
        expect_done = 0;
        if (b_txv === 1'b1 && b_ready) begin
          tests++;
          exp_b = (q.size() > 0) ? q.pop_front() : 8'hxx;
          if (b_txd !== exp_b) begin
            fails++;
            $display("FAIL p_byte_%0d: got %02h, required %02h", xfers, b_txd, exp_b);
          end
          xfers++;
          if (xfers == 8) expect_done = 1;
        end
        @(negedge clk);
      end
    end
    tests++;
    if (!fin || xfers != 8) begin
      fails++;
      $display("FAIL p_dump_end: finished=%0d bytes=%0d, required 1 8", fin, xfers);
    end
    $display("[TB] param dump: %0d bytes", xfers);
    check_idle(2, "after_param");
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_param();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
